// File: rtl/tim1_cc_channel_pkg.sv
// Shared TIM1 capture/compare definitions: output-compare mode encodings
// and the default counter width.
package tim1_cc_channel_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      OC_FROZEN = 3'b000,
      OC_SET    = 3'b001,
      OC_CLEAR  = 3'b010,
      OC_TOGGLE = 3'b011,
      OC_FLOW   = 3'b100,
      OC_FHIGH  = 3'b101,
      OC_PWM1   = 3'b110,
      OC_PWM2   = 3'b111
   } oc_mode_e;

endpackage

// File: rtl/tim1_cc_channel_if.sv
// CCR register bus and flag outputs of one TIM1 capture/compare channel.
// The controller (master) writes CCR and clears flags; the channel (slave)
// returns the active CCR, the flags and the interrupt pulse.
interface tim1_cc_channel_if #(
   parameter int CNT_W = 16
);
   logic             wr_ccr;
   logic [CNT_W-1:0] i_data_ccr;
   logic             clr_ccf;
   logic             clr_ccof;
   logic [CNT_W-1:0] o_ccr;
   logic             cc_flag;
   logic             ccof_flag;
   logic             cc_irq;

   modport master (
      output wr_ccr, i_data_ccr, clr_ccf, clr_ccof,
      input  o_ccr, cc_flag, ccof_flag, cc_irq
   );

   modport slave (
      input  wr_ccr, i_data_ccr, clr_ccf, clr_ccof,
      output o_ccr, cc_flag, ccof_flag, cc_irq
   );
endinterface

// File: rtl/tim1_cc_channel_ic_sync.sv
// Capture-input synchroniser and edge detector. The pin passes through
// SYNC_STAGES flops; the pulse is high for one cycle when the synchronised
// level shows the selected edge (ic_edge: 0 rising, 1 falling).
module tim1_ic_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ic_in,
   input  logic ic_edge,
   output logic o_edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Shift the asynchronous pin through the synchroniser and keep the last level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ic_in};
         prev_q <= sync_out;
      end
   end

   // Compare current and previous synchronised level for the selected edge.
   always_comb begin
      o_edge_pulse = 1'b0;
      if (ic_edge) o_edge_pulse = prev_q & ~sync_out;
      else         o_edge_pulse = sync_out & ~prev_q;
   end

endmodule

// File: rtl/tim1_cc_channel.sv
// TIM1 capture/compare channel: preloadable CCR, output compare / PWM
// generation, input capture on a synchronised pin edge, and the
// capture/overcapture flags with their interrupt pulse.
module tim1_cc_channel
   import tim1_cc_channel_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             timer_en,
   input  logic [CNT_W-1:0] tim1_cnt,
   input  logic             dir,
   input  logic             cnt_ov,
   input  logic             cnt_uv,
   input  logic             cc_sel,
   input  logic [2:0]       oc_mode,
   input  logic             cc_pol,
   input  logic             preload_en,
   input  logic             ic_edge,
   input  logic             ic_in,
   output logic             oc_out,
   tim1_cc_channel_if.slave bus
);

   logic [CNT_W-1:0] ccr_shadow;
   logic [CNT_W-1:0] ccr_active;
   logic             oc_ref;
   logic             oc_ref_nxt;
   logic             match_d;
   logic             uev;
   logic             match;
   logic             match_evt;
   logic             edge_pulse;
   logic             cap_evt;
   logic             set_cc;
   logic             cc_flag_q;
   logic             ccof_flag_q;
   logic             cc_irq_q;
   oc_mode_e         mode;

   // Counter direction does not affect compare; kept for interface completeness.
   logic             dir_unused;
   assign dir_unused = dir;

   assign mode = oc_mode_e'(oc_mode);

   tim1_ic_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ic_sync (
      .clk          (clk),
      .rst          (rst),
      .ic_in        (ic_in),
      .ic_edge      (ic_edge),
      .o_edge_pulse (edge_pulse)
   );

   // Event decode: update event, compare match edge and capture edge.
   always_comb begin
      uev       = timer_en & (cnt_ov | cnt_uv);
      match     = timer_en & (tim1_cnt == ccr_active) & ~cc_sel;
      match_evt = match & ~match_d;
      cap_evt   = cc_sel & edge_pulse;
      set_cc    = match_evt | cap_evt;
   end

   // Next reference level per compare mode; PWM/force modes track the
   // counter even while it is stopped.
   always_comb begin
      oc_ref_nxt = oc_ref;
      case (mode)
         OC_FROZEN: oc_ref_nxt = oc_ref;
         OC_SET:    if (match_evt) oc_ref_nxt = 1'b1;
         OC_CLEAR:  if (match_evt) oc_ref_nxt = 1'b0;
         OC_TOGGLE: if (match_evt) oc_ref_nxt = ~oc_ref;
         OC_FLOW:   oc_ref_nxt = 1'b0;
         OC_FHIGH:  oc_ref_nxt = 1'b1;
         OC_PWM1:   oc_ref_nxt = (tim1_cnt <  ccr_active);
         OC_PWM2:   oc_ref_nxt = (tim1_cnt >= ccr_active);
         default:   oc_ref_nxt = oc_ref;
      endcase
   end

   // CCR registers: capture in input mode; direct or preloaded writes in
   // compare mode, where a write coinciding with an update still transfers
   // the previous shadow value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ccr_shadow <= '0;
         ccr_active <= '0;
      end else if (cc_sel) begin
         if (cap_evt) ccr_active <= tim1_cnt;
      end else begin
         if (bus.wr_ccr && preload_en) ccr_shadow <= bus.i_data_ccr;
         if (bus.wr_ccr && !preload_en) ccr_active <= bus.i_data_ccr;
         else if (preload_en && uev)    ccr_active <= ccr_shadow;
      end
   end

   // Compare reference register and match history (cleared in capture mode
   // because match is gated by cc_sel).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oc_ref  <= 1'b0;
         match_d <= 1'b0;
      end else begin
         oc_ref  <= oc_ref_nxt;
         match_d <= match;
      end
   end

   // Status flags: a set event always wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cc_flag_q   <= 1'b0;
         ccof_flag_q <= 1'b0;
         cc_irq_q    <= 1'b0;
      end else begin
         cc_flag_q   <= set_cc | (cc_flag_q & ~bus.clr_ccf);
         ccof_flag_q <= (cap_evt & cc_flag_q) | (ccof_flag_q & ~bus.clr_ccof);
         cc_irq_q    <= set_cc;
      end
   end

   assign oc_out        = oc_ref ^ cc_pol;
   assign bus.o_ccr     = ccr_active;
   assign bus.cc_flag   = cc_flag_q;
   assign bus.ccof_flag = ccof_flag_q;
   assign bus.cc_irq    = cc_irq_q;

endmodule
